// File: rtl/program_mem_arbiter.sv
// Round-robin arbiter sharing one program-memory read channel among NUM_CONSUMERS fetchers.
// Optional last-access bypass enabled by defining PROG_ARB_LAST_HIT_EN.
module program_mem_arbiter #(
    parameter int ADDRESS_BITS  = 8,
    parameter int DATA_BITS     = 16,
    parameter int NUM_CONSUMERS = 4
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic [NUM_CONSUMERS-1:0]              consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDRESS_BITS-1:0] consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]              consumer_read_ready,
    output logic [NUM_CONSUMERS*DATA_BITS-1:0]    consumer_read_data,
    output logic                                  mem_read_valid,
    output logic [ADDRESS_BITS-1:0]               mem_read_address,
    input  logic                                  mem_read_ready,
    input  logic [DATA_BITS-1:0]                  mem_read_data
);

    localparam int PTR_W = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        READ_WAITING = 2'd1,
        RELAYING     = 2'd2
    } state_t;

    state_t                             state, state_next;
    logic [PTR_W-1:0]                   rr_ptr, rr_next;
    logic [PTR_W-1:0]                   grant, grant_next;
    logic [DATA_BITS-1:0]               data_reg, data_next;
    logic                               mem_valid_next;
    logic [ADDRESS_BITS-1:0]            mem_addr_next;
    logic [NUM_CONSUMERS-1:0]           ready_next;
    logic [NUM_CONSUMERS*DATA_BITS-1:0] cdata_next;

    logic                    found;
    logic [PTR_W-1:0]        winner;
    logic [PTR_W-1:0]        idx;
    logic [ADDRESS_BITS-1:0] win_addr;
    logic                    hit;
    logic [DATA_BITS-1:0]    hit_data;

    // First requester at or after rr_ptr, wrapping around.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            idx = PTR_W'((int'(rr_ptr) + i) % NUM_CONSUMERS);
            if (!found && consumer_read_valid[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    assign win_addr = consumer_read_address[int'(winner)*ADDRESS_BITS +: ADDRESS_BITS];

`ifdef PROG_ARB_LAST_HIT_EN
    logic                    last_valid, last_valid_next;
    logic [ADDRESS_BITS-1:0] last_addr, last_addr_next;
    logic [DATA_BITS-1:0]    last_data, last_data_next;

    assign hit      = last_valid && (win_addr == last_addr);
    assign hit_data = last_data;

    always_comb begin
        last_valid_next = last_valid;
        last_addr_next  = last_addr;
        last_data_next  = last_data;
        if (state == READ_WAITING && mem_read_ready) begin
            last_valid_next = 1'b1;
            last_addr_next  = mem_read_address;
            last_data_next  = mem_read_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_valid <= 1'b0;
            last_addr  <= '0;
            last_data  <= '0;
        end else begin
            last_valid <= last_valid_next;
            last_addr  <= last_addr_next;
            last_data  <= last_data_next;
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_comb begin
        state_next     = state;
        rr_next        = rr_ptr;
        grant_next     = grant;
        data_next      = data_reg;
        mem_valid_next = mem_read_valid;
        mem_addr_next  = mem_read_address;
        ready_next     = consumer_read_ready;
        cdata_next     = consumer_read_data;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_next = winner;
                    rr_next    = PTR_W'((int'(winner) + 1) % NUM_CONSUMERS);
                    if (hit) begin
                        ready_next[winner] = 1'b1;
                        cdata_next[int'(winner)*DATA_BITS +: DATA_BITS] = hit_data;
                        state_next = RELAYING;
                    end else begin
                        mem_addr_next  = win_addr;
                        mem_valid_next = 1'b1;
                        state_next     = READ_WAITING;
                    end
                end
            end
            READ_WAITING: begin
                if (mem_read_ready) begin
                    data_next      = mem_read_data;
                    mem_valid_next = 1'b0;
                    // A withdrawn request still completes the read, but the word is dropped.
                    if (consumer_read_valid[grant]) begin
                        ready_next[grant] = 1'b1;
                        cdata_next[int'(grant)*DATA_BITS +: DATA_BITS] = mem_read_data;
                        state_next = RELAYING;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            RELAYING: begin
                if (!consumer_read_valid[grant]) begin
                    ready_next[grant] = 1'b0;
                    state_next        = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state               <= IDLE;
            rr_ptr              <= '0;
            grant               <= '0;
            data_reg            <= '0;
            mem_read_valid      <= 1'b0;
            mem_read_address    <= '0;
            consumer_read_ready <= '0;
            consumer_read_data  <= '0;
        end else begin
            state               <= state_next;
            rr_ptr              <= rr_next;
            grant               <= grant_next;
            data_reg            <= data_next;
            mem_read_valid      <= mem_valid_next;
            mem_read_address    <= mem_addr_next;
            consumer_read_ready <= ready_next;
            consumer_read_data  <= cdata_next;
        end
    end

endmodule

// File: tb/tb_program_mem_arbiter.sv
// Scoreboard bench for program_mem_arbiter: directed requests, memory responder, ready monitor.
module tb_program_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int DW = 16;

    logic            clk;
    logic            reset;
    logic [N-1:0]    consumer_read_valid;
    logic [N*AW-1:0] consumer_read_address;
    logic [N-1:0]    consumer_read_ready;
    logic [N*DW-1:0] consumer_read_data;
    logic            mem_read_valid;
    logic [AW-1:0]   mem_read_address;
    logic            mem_read_ready;
    logic [DW-1:0]   mem_read_data;

    program_mem_arbiter #(.ADDRESS_BITS(AW), .DATA_BITS(DW), .NUM_CONSUMERS(N)) dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (consumer_read_valid),
        .consumer_read_address (consumer_read_address),
        .consumer_read_ready   (consumer_read_ready),
        .consumer_read_data    (consumer_read_data),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data)
    );

    typedef struct {
        int          c;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mem_lat  = 2;
    int   mem_reads = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] mem_word(input logic [7:0] a);
        return (a == 8'h15) ? 16'hA3C1 : {~a, a};
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Memory responder: asserts ready for one cycle mem_lat cycles after the request appears.
    initial begin
        int wait_cnt;
        wait_cnt       = 0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        forever begin
            @(negedge clk);
            mem_read_ready = 1'b0;
            if (mem_read_valid) begin
                wait_cnt++;
                if (wait_cnt >= mem_lat) begin
                    mem_read_ready = 1'b1;
                    mem_read_data  = mem_word(mem_read_address);
                    wait_cnt       = 0;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every rising ready bit pops the scoreboard.
    initial begin
        logic [N-1:0]  prev_ready;
        logic          prev_mv;
        logic [AW-1:0] held;
        exp_t          e;
        prev_ready = '0;
        prev_mv    = 1'b0;
        held       = '0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (consumer_read_ready[i] && !prev_ready[i]) begin
                    checks++;
                    if (sb.size() == 0) begin
                        failures++;
                        $display("FAIL ready_unexpected consumer=%0d data=%h expected none", i,
                                 consumer_read_data[i*DW +: DW]);
                    end else begin
                        e = sb.pop_front();
                        if (e.c != i || consumer_read_data[i*DW +: DW] != e.d) begin
                            failures++;
                            $display("FAIL ready_order got consumer=%0d data=%h expected consumer=%0d data=%h",
                                     i, consumer_read_data[i*DW +: DW], e.c, e.d);
                        end
                    end
                end
            end
            if (consumer_read_ready != '0) begin
                checks++;
                if ($countones(consumer_read_ready) > 1) begin
                    failures++;
                    $display("FAIL ready_onehot got=%b expected at most one bit", consumer_read_ready);
                end
            end
            if (mem_read_valid && !prev_mv) begin
                mem_reads++;
                held = mem_read_address;
            end else if (mem_read_valid && prev_mv) begin
                checks++;
                if (mem_read_address != held) begin
                    failures++;
                    $display("FAIL addr_hold got=%h expected=%h", mem_read_address, held);
                end
            end
            prev_ready = consumer_read_ready;
            prev_mv    = mem_read_valid;
        end
    end

    // Fetcher behaviour: drop valid once ready is seen; ready must fall one cycle later.
    logic [N-1:0] dropped = '0;

    task automatic tick();
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            if (dropped[i]) begin
                checks++;
                if (consumer_read_ready[i]) begin
                    failures++;
                    $display("FAIL ready_drop consumer=%0d got=1 expected=0", i);
                end
            end
        end
        dropped = '0;
        for (int i = 0; i < N; i++) begin
            if (consumer_read_valid[i] && consumer_read_ready[i]) begin
                consumer_read_valid[i] = 1'b0;
                dropped[i]             = 1'b1;
            end
        end
    endtask

    task automatic do_read(input int c, input logic [7:0] a, output int lat);
        consumer_read_address[c*AW +: AW] = a;
        consumer_read_valid[c]            = 1'b1;
        sb.push_back('{c, mem_word(a)});
        lat = 0;
        while (consumer_read_valid[c] && lat < 200) begin
            tick();
            lat++;
        end
        checks++;
        if (consumer_read_valid[c]) begin
            failures++;
            $display("FAIL read_timeout consumer=%0d got=no ready expected=ready", c);
            consumer_read_valid[c] = 1'b0;
        end
        tick();
    endtask

    task automatic wait_all();
        int n;
        n = 0;
        while (consumer_read_valid != '0 && n < 400) begin
            tick();
            n++;
        end
        checks++;
        if (consumer_read_valid != '0) begin
            failures++;
            $display("FAIL serve_timeout got valid=%b expected=0", consumer_read_valid);
            consumer_read_valid = '0;
        end
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int r0;
        reset                 = 1'b1;
        consumer_read_valid   = 4'hF;
        consumer_read_address = {8'h23, 8'h22, 8'h21, 8'h20};
        mem_lat               = 2;
        repeat (3) tick();
        #2;
        chk("reset_ready", consumer_read_ready, 0);
        chk("reset_data", consumer_read_data, 0);
        chk("reset_mem_valid", mem_read_valid, 0);
        chk("reset_mem_addr", mem_read_address, 0);

        // Round 1 from reset: order 0,1,2,3
        for (int i = 0; i < N; i++) sb.push_back('{i, mem_word(8'(8'h20 + i))});
        tick();
        reset = 1'b0;
        r0 = mem_reads;
        wait_all();
        chk("round1_mem_reads", mem_reads - r0, 4);

        // Round 2: pointer wrapped back to consumer 0
        consumer_read_valid = 4'hF;
        for (int i = 0; i < N; i++) sb.push_back('{i, mem_word(8'(8'h20 + i))});
        r0 = mem_reads;
        wait_all();
        chk("round2_mem_reads", mem_reads - r0, 4);

        // Single request, 3-cycle memory
        mem_lat = 3;
        do_read(2, 8'h15, lat);
        chk("c2_latency", lat, 4);

        // rr_ptr now at 3: consumers 0 and 3 together -> 3 first, then 0
        mem_lat = 2;
        consumer_read_address[3*AW +: AW] = 8'h60;
        consumer_read_address[0*AW +: AW] = 8'h61;
        consumer_read_valid = 4'b1001;
        sb.push_back('{3, mem_word(8'h60)});
        sb.push_back('{0, mem_word(8'h61)});
        wait_all();

        // Minimum latency
        mem_lat = 1;
        do_read(1, 8'h40, lat);
        chk("min_latency", lat, 2);

        // Withdraw during READ_WAITING
        mem_lat = 4;
        r0 = mem_reads;
        consumer_read_address[1*AW +: AW] = 8'h31;
        consumer_read_valid[1] = 1'b1;
        tick();
        tick();
        consumer_read_valid[1] = 1'b0;
        repeat (8) tick();
        chk("withdraw_ready", consumer_read_ready, 0);
        chk("withdraw_mem_reads", mem_reads - r0, 1);
        chk("withdraw_mem_valid", mem_read_valid, 0);
        do_read(1, 8'h33, lat);
        chk("after_withdraw_latency", lat, 5);

        // Asynchronous reset in READ_WAITING
        mem_lat = 6;
        consumer_read_address[0*AW +: AW] = 8'h50;
        consumer_read_valid[0] = 1'b1;
        tick();
        tick();
        chk("pre_reset_mem_valid", mem_read_valid, 1);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_mem_valid", mem_read_valid, 0);
        consumer_read_valid[0] = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        repeat (10) tick();
        chk("post_reset_ready", consumer_read_ready, 0);
        chk("post_reset_mem_valid", mem_read_valid, 0);

        // Repeated address
        mem_lat = 2;
        do_read(0, 8'h08, lat);
        chk("first_08_latency", lat, 3);
        r0 = mem_reads;
        do_read(3, 8'h08, lat);
`ifdef PROG_ARB_LAST_HIT_EN
        chk("hit_mem_reads", mem_reads - r0, 0);
        chk("hit_latency", lat, 1);
`else
        chk("repeat_mem_reads", mem_reads - r0, 1);
        chk("repeat_latency", lat, 3);
`endif
        r0 = mem_reads;
        do_read(1, 8'h09, lat);
        chk("miss_09_mem_reads", mem_reads - r0, 1);
        chk("miss_09_latency", lat, 3);

        repeat (3) tick();
        chk("scoreboard_empty", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
